// File: rtl/bram_stream_reader_if.sv
// Bus bundle for bram_stream_reader: command channel, RAM read port and output stream.
// Optional macro STREAM_LAST_EN adds the out_last end-of-command marker.
// master = the reader itself, slave = the environment (command source, RAM, consumer).
interface bram_stream_reader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W:0]   cmd_len;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_en;
    logic              ram_regce;
    logic [DATA_W-1:0] ram_dout;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;
`ifdef STREAM_LAST_EN
    logic              out_last;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
        output cmd_ready, ram_addr, ram_en, ram_regce, out_valid, out_data, busy, out_last
    );
    modport slave (
        output cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
        input  cmd_ready, ram_addr, ram_en, ram_regce, out_valid, out_data, busy, out_last
    );
`else
    modport master (
        input  cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
        output cmd_ready, ram_addr, ram_en, ram_regce, out_valid, out_data, busy
    );
    modport slave (
        output cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
        input  cmd_ready, ram_addr, ram_en, ram_regce, out_valid, out_data, busy
    );
`endif
endinterface

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: turns {start address, length} commands into sequential RAM reads,
// hides the RAM read latency and delivers the words as a valid/ready stream through a
// small first-word-fall-through buffer.
// Optional macro STREAM_LAST_EN: adds out_last, flagging the final word of each command.
// Reads are only issued while the words already in flight plus those buffered (minus the
// word leaving this cycle) leave room, so the buffer can never overflow.
module bram_stream_reader #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic                 clka,
    input logic                 rstb,
    bram_stream_reader_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]    CNT_ZERO  = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    // Number of set bits in the latency shift register (reads still inside the RAM).
    function automatic logic [CNT_W-1:0] popcnt(input logic [RD_LATENCY-1:0] v);
        logic [CNT_W-1:0] acc;
        acc = {CNT_W{1'b0}};
        for (int i = 0; i < RD_LATENCY; i++) begin
            acc = acc + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return acc;
    endfunction

    logic [1:0]            state_q,    state_d;
    logic [ADDR_W-1:0]     cur_q,      cur_d;
    logic [ADDR_W:0]       rem_q,      rem_d;
    logic                  ram_en_q,   ram_en_d;
    logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
    logic [RD_LATENCY-1:0] sr_q,       sr_d;
    logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
    logic [PTR_W:0]        cnt_q,      cnt_d;
    logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
`ifdef STREAM_LAST_EN
    logic                  ram_last_q, ram_last_d;
    logic [RD_LATENCY-1:0] lsr_q,      lsr_d;
    logic                  last_mem_q [FIFO_DEPTH];
`endif

    logic                  push_s;
    logic                  pop_s;
    logic [CNT_W-1:0]      outstanding_s;
    logic                  credit_s;

    assign push_s        = sr_q[RD_LATENCY-1];
    assign pop_s         = (cnt_q != CNT_ZERO) & bus.out_ready;
    assign outstanding_s = {{(CNT_W-1){1'b0}}, ram_en_q} + popcnt(sr_q)
                         + {{(CNT_W-PTR_W-1){1'b0}}, cnt_q} - {{(CNT_W-1){1'b0}}, pop_s};
    assign credit_s      = (outstanding_s < DEPTH_C);

    // Command sequencing: accept commands in IDLE, issue reads in RUN, wait out the tail in DRAIN.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        rem_d      = rem_q;
        ram_en_d   = 1'b0;
        ram_addr_d = ram_addr_q;
`ifdef STREAM_LAST_EN
        ram_last_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && (bus.cmd_len != LEN_ZERO)) begin
                    // The buffer is empty in IDLE, so the first read goes out immediately.
                    ram_en_d   = 1'b1;
                    ram_addr_d = bus.cmd_addr;
                    cur_d      = bus.cmd_addr + ADDR_ONE;
                    rem_d      = bus.cmd_len - LEN_ONE;
`ifdef STREAM_LAST_EN
                    ram_last_d = (bus.cmd_len == LEN_ONE);
`endif
                    state_d    = (bus.cmd_len == LEN_ONE) ? ST_DRAIN : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (credit_s) begin
                    ram_en_d   = 1'b1;
                    ram_addr_d = cur_q;
                    cur_d      = cur_q + ADDR_ONE;
                    rem_d      = rem_q - LEN_ONE;
`ifdef STREAM_LAST_EN
                    ram_last_d = (rem_q == LEN_ONE);
`endif
                    state_d    = (rem_q == LEN_ONE) ? ST_DRAIN : ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Leave once nothing is in flight and the buffer is empty after this cycle.
                if (!ram_en_q && (sr_q == {RD_LATENCY{1'b0}}) &&
                    ((cnt_q == CNT_ZERO) || ((cnt_q == CNT_ONE) && pop_s))) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latency shift register: bit 0 follows the issued read, the tail marks data arriving.
    always_comb begin
        sr_d[0] = ram_en_q;
`ifdef STREAM_LAST_EN
        lsr_d[0] = ram_last_q;
`endif
        for (int i = 1; i < RD_LATENCY; i++) begin
            sr_d[i] = sr_q[i-1];
`ifdef STREAM_LAST_EN
            lsr_d[i] = lsr_q[i-1];
`endif
        end
    end

    // Buffer pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control and pointer registers; reset drops all in-flight reads.
    always_ff @(posedge clka) begin
        if (rstb) begin
            state_q    <= ST_IDLE;
            cur_q      <= {ADDR_W{1'b0}};
            rem_q      <= LEN_ZERO;
            ram_en_q   <= 1'b0;
            ram_addr_q <= {ADDR_W{1'b0}};
            sr_q       <= {RD_LATENCY{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            cnt_q      <= CNT_ZERO;
`ifdef STREAM_LAST_EN
            ram_last_q <= 1'b0;
            lsr_q      <= {RD_LATENCY{1'b0}};
`endif
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            rem_q      <= rem_d;
            ram_en_q   <= ram_en_d;
            ram_addr_q <= ram_addr_d;
            sr_q       <= sr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
`ifdef STREAM_LAST_EN
            ram_last_q <= ram_last_d;
            lsr_q      <= lsr_d;
`endif
        end
    end

    // Buffer storage; cleared on reset so out_data reads 0 while empty after reset.
    always_ff @(posedge clka) begin
        if (rstb) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
`ifdef STREAM_LAST_EN
                last_mem_q[i] <= 1'b0;
`endif
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= bus.ram_dout;
`ifdef STREAM_LAST_EN
            last_mem_q[wr_ptr_q] <= lsr_q[RD_LATENCY-1];
`endif
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_regce = 1'b1;
    assign bus.out_valid = (cnt_q != CNT_ZERO);
    assign bus.out_data  = mem_q[rd_ptr_q];
`ifdef STREAM_LAST_EN
    assign bus.out_last  = (cnt_q != CNT_ZERO) & last_mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: RAM model preloaded with word = address,
// reference model is a queue of expected words built from {addr, len} with modular arithmetic.
module tb_bram_stream_reader;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;

    logic clka = 1'b0;
    logic rstb;
    always #5 clka = ~clka;

    bram_stream_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    bram_stream_reader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LATENCY(2), .FIFO_DEPTH(4)
    ) dut (
        .clka(clka),
        .rstb(rstb),
        .bus (bus.master)
    );

    // RAM model, HIGH_PERFORMANCE mode: 2 clocks from ram_en to ram_dout.
    logic [DATA_W-1:0] ram [1024];
    logic [DATA_W-1:0] lat1;
    always @(posedge clka) begin
        if (bus.ram_en) lat1 <= ram[bus.ram_addr];
        if (bus.ram_regce) bus.ram_dout <= lat1;
    end

    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] exp_q[$];
    bit                exp_last_q[$];
    int  outstanding;
    bit  mon_en;
    bit  prev_stall;
    logic [DATA_W-1:0] prev_data;
    int  cyc, first_valid_cyc, got, first_pop, last_pop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive out_ready, observe mid-cycle at the falling edge, return after the rising edge.
    task automatic cycle(input logic rdy);
        bus.out_ready = rdy;
        @(negedge clka);
        if (mon_en) begin
            cyc++;
            if (bus.out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                check("stall_data", {16'd0, bus.out_data}, {16'd0, prev_data});
            end
            if (bus.ram_en === 1'b1) outstanding++;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                check("word_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    check("data", {16'd0, bus.out_data}, {16'd0, exp_q.pop_front()});
`ifdef STREAM_LAST_EN
                    check("last", {31'd0, bus.out_last}, {31'd0, exp_last_q.pop_front()});
`else
                    void'(exp_last_q.pop_front());
`endif
                end
                outstanding--;
                got++;
                if (got == 1) first_pop = cyc;
                last_pop = cyc;
            end
            check("credit", {31'd0, outstanding <= 4}, 32'd1);
            prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
            prev_data  = bus.out_data;
        end
        @(posedge clka);
        #1;
    endtask

    // Offer one command in the current cycle (expected to be accepted) and record expected words.
    task automatic send_cmd(input int addr, input int len, input logic rdy);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = ADDR_W'(addr);
        bus.cmd_len   = (ADDR_W+1)'(len);
        check("cmd_ready_at_cmd", {31'd0, bus.cmd_ready}, 32'd1);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(DATA_W'((addr + i) % 1024));
            exp_last_q.push_back(i == len - 1);
        end
        cyc = -1; first_valid_cyc = -1; got = 0;
        cycle(rdy);
        bus.cmd_valid = 1'b0;
    endtask

    // Consume until the model is empty (mode 0: ready=1, 1: alternate, 2: random), then expect IDLE.
    task automatic run(input string tag, input int mode, input int budget);
        logic r;
        for (int n = 0; n < budget && exp_q.size() != 0; n++) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? logic'(n % 2 == 0) : logic'($urandom_range(0, 1));
            cycle(r);
        end
        check({tag, "_all_words"}, exp_q.size(), 32'd0);
        for (int n = 0; n < 4 && bus.cmd_ready !== 1'b1; n++) cycle(1'b1);
        check({tag, "_idle"}, {31'd0, bus.cmd_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = DATA_W'(i);
        lat1 = '0; bus.ram_dout = '0;
        rstb = 1'b1; mon_en = 1'b0; prev_stall = 1'b0; outstanding = 0;
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.out_ready = 1'b0;
        repeat (3) cycle(1'b0);

        // Reset values
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_ram_en", {31'd0, bus.ram_en}, 32'd0);
        check("rst_ram_addr", {22'd0, bus.ram_addr}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_out_data", {16'd0, bus.out_data}, 32'd0);
        check("ram_regce", {31'd0, bus.ram_regce}, 32'd1);
`ifdef STREAM_LAST_EN
        check("rst_out_last", {31'd0, bus.out_last}, 32'd0);
`endif
        rstb = 1'b0;
        mon_en = 1'b1;
        cycle(1'b1);

        // 1. Basic: first out_valid in cycle 4, four words on consecutive clocks
        send_cmd(32'h010, 4, 1'b1);
        check("basic_busy", {31'd0, bus.busy}, 32'd1);
        run("basic", 0, 40);
        check("basic_first_valid", first_valid_cyc, 32'd4);
        check("basic_consecutive", last_pop - first_pop, 32'd3);

        // 2. Backpressure: alternating then random out_ready
        send_cmd($urandom_range(0, 1023), 8, 1'b1);
        run("bp_alt", 1, 80);
        send_cmd($urandom_range(0, 1023), 8, 1'b0);
        run("bp_rand", 2, 120);

        // Random commands with random backpressure
        for (int k = 0; k < 6; k++) begin
            send_cmd($urandom_range(0, 1023), $urandom_range(1, 24), 1'b1);
            run("rand_cmd", 2, 400);
        end

        // Full-range length
        send_cmd($urandom_range(0, 1023), 1024, 1'b1);
        run("len_max", 0, 1200);

        // 3. Wrap: 0x3FE,0x3FF,0x000,0x001
        send_cmd(32'h3FE, 4, 1'b1);
        run("wrap", 0, 40);

        // 4. Zero length: no reads, no output, command port free next cycle
        send_cmd(32'h055, 0, 1'b1);
        check("zero_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        for (int n = 0; n < 6; n++) begin
            check("zero_ram_en", {31'd0, bus.ram_en}, 32'd0);
            check("zero_out_valid", {31'd0, bus.out_valid}, 32'd0);
            cycle(1'b1);
        end

        // 5. Reset after the 3rd of 8 words
        send_cmd(32'h100, 8, 1'b1);
        for (int n = 0; n < 40 && got < 3; n++) cycle(1'b1);
        check("mid_three_words", got, 32'd3);
        rstb = 1'b1;
        cycle(1'b0);
        rstb = 1'b0;
        exp_q.delete(); exp_last_q.delete(); outstanding = 0; prev_stall = 1'b0;
        check("mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        for (int n = 0; n < 8; n++) begin
            check("mid_no_stale", {31'd0, bus.out_valid}, 32'd0);
            cycle(1'b1);
        end
        send_cmd(32'h020, 2, 1'b1);
        run("after_rst", 0, 40);

`ifdef STREAM_LAST_EN
        // 6. End-of-command marking (checked per word in the monitor)
        send_cmd(32'h040, 3, 1'b1);
        run("last3", 0, 40);
        send_cmd(32'h077, 1, 1'b0);
        run("last1", 1, 40);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
